// File: rtl/tt_um_sps_match_driver.sv
// Stone-paper-scissors match controller: conditions the commit button, draws the
// opponent move from an LFSR, starts rounds, scores a first-to-N match, flags timeouts.
`default_nettype none

module tt_um_sps_match_driver #(
  parameter int         WINS_TO_MATCH = 3,
  parameter int         TIMEOUT       = 255,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam logic [2:0] WIN_SCORE    = 3'(WINS_TO_MATCH);
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic       sync1, sync2, sync3, commit_pulse;
  logic [7:0] lfsr;
  logic [1:0] p1_move, p1_move_nxt, p2_move, p2_move_nxt;
  logic [2:0] p1_score, p1_score_nxt, p2_score, p2_score_nxt;
  logic       match_over, match_over_nxt, timeout_err, timeout_err_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] opp_move;
  logic [1:0] result_code;
  logic       result_valid;
  logic       unused;

  assign result_code  = uio_in[1:0];
  assign result_valid = uio_in[2];
  assign unused       = &{1'b0, ui_in[7:3], uio_in[7:3]};

  // Code 3 is folded onto stone/paper so the opponent never sends an invalid move.
  assign opp_move = (lfsr[1:0] == 2'd3) ? {1'b0, lfsr[2]} : lfsr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      commit_pulse <= 1'b0;
      lfsr         <= LFSR_SEED;
      p1_move      <= 2'd0;
      p2_move      <= 2'd0;
      p1_score     <= 3'd0;
      p2_score     <= 3'd0;
      match_over   <= 1'b0;
      timeout_err  <= 1'b0;
      cnt          <= 8'd0;
    end else if (ena) begin
      state        <= state_nxt;
      sync1        <= ui_in[0];
      sync2        <= sync1;
      sync3        <= sync2;
      commit_pulse <= sync2 & ~sync3;
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      p1_move      <= p1_move_nxt;
      p2_move      <= p2_move_nxt;
      p1_score     <= p1_score_nxt;
      p2_score     <= p2_score_nxt;
      match_over   <= match_over_nxt;
      timeout_err  <= timeout_err_nxt;
      cnt          <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    p1_move_nxt     = p1_move;
    p2_move_nxt     = p2_move;
    p1_score_nxt    = p1_score;
    p2_score_nxt    = p2_score;
    match_over_nxt  = match_over;
    timeout_err_nxt = timeout_err;
    cnt_nxt         = cnt;
    case (state)
      IDLE: begin
        if (commit_pulse) begin
          p1_move_nxt     = ui_in[2:1];
          p2_move_nxt     = opp_move;
          timeout_err_nxt = 1'b0;
          state_nxt       = SEND;
        end
      end
      SEND: begin
        cnt_nxt   = TIMEOUT_LOAD;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A result arriving on the last counted cycle takes priority over the timeout.
        if (result_valid) begin
          if (result_code == 2'b01) p1_score_nxt = p1_score + 3'd1;
          else if (result_code == 2'b10) p2_score_nxt = p2_score + 3'd1;
          if (p1_score_nxt == WIN_SCORE || p2_score_nxt == WIN_SCORE) begin
            match_over_nxt = 1'b1;
            state_nxt      = DONE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt_nxt == 8'd0) begin
            timeout_err_nxt = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end
      DONE: begin
        if (commit_pulse) begin
          p1_score_nxt    = 3'd0;
          p2_score_nxt    = 3'd0;
          match_over_nxt  = 1'b0;
          timeout_err_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign uio_out = {3'b000, p2_move, p1_move, state == SEND};
  assign uio_oe  = 8'h1F;
  assign uo_out  = {timeout_err, match_over, p2_score, p1_score};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_sps_match_driver.sv
// Scoreboarded bench for tt_um_sps_match_driver: the bench plays the game core
// and checks moves, start strobes, scores, match end and timeouts against a model.
`default_nettype none

module tb_tt_um_sps_match_driver;

  localparam int         W    = 3;
  localparam int         T    = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uio_out, uio_oe, uo_out;

  tt_um_sps_match_driver #(.WINS_TO_MATCH(W), .TIMEOUT(T), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_count = 0;
  logic prev_start = 1'b0;
  logic [1:0] move_q[$];

  // High-level model of the match
  logic [2:0] s1 = 3'd0, s2 = 3'd0;
  logic       mo = 1'b0, to = 1'b0;
  logic [7:0] m_lfsr = SEED, m_prev = SEED;

  function automatic logic [7:0] lfsr_step(logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [1:0] opp(logic [7:0] l);
    return (l[1:0] == 2'd3) ? {1'b0, l[2]} : l[1:0];
  endfunction

  function automatic logic [7:0] exp_uo();
    return {to, mo, s2, s1};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_prev = m_lfsr;
    if (!rst_n) m_lfsr = SEED;
    else if (ena) m_lfsr = lfsr_step(m_lfsr);
  end

  // Monitor: every start strobe pops the expected P1 move from the scoreboard.
  always @(negedge clk) begin
    if (uio_out[0] === 1'b1) begin
      start_count++;
      check("start_width", {31'd0, prev_start}, 32'd0);
      if (move_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got start=1 expected no start at %0t", $time);
      end else begin
        check("p1_move", {30'd0, uio_out[2:1]}, {30'd0, move_q.pop_front()});
        check("p2_move", {30'd0, uio_out[4:3]}, {30'd0, opp(m_prev)});
      end
    end
    prev_start = uio_out[0];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    s1 = 3'd0; s2 = 3'd0; mo = 1'b0; to = 1'b0;
    move_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = 8'($urandom);
    uio_in = 8'($urandom);
    tick(2);
    #1;
    check("rst_uo_out", {24'd0, uo_out}, 32'h00);
    check("rst_uio_out", {24'd0, uio_out}, 32'h00);
    check("rst_uio_oe", {24'd0, uio_oe}, 32'h1F);
    ui_in = 8'h00;
    uio_in = 8'h00;
    model_reset();
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Press commit; if a round is expected, returns on the negedge where start is seen.
  task automatic commit(logic [1:0] mv, bit expect_start);
    int n = 0;
    int sc = start_count;
    ui_in[2:1] = mv;
    if (expect_start) move_q.push_back(mv);
    ui_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      if (uio_out[0] === 1'b1) begin
        n = i;
        break;
      end
    end
    ui_in[0] = 1'b0;
    if (expect_start) begin
      to = 1'b0;
      check("commit_latency", n, 4);
      check("to_clear_on_commit", {31'd0, uo_out[7]}, 32'd0);
    end else begin
      s1 = 3'd0; s2 = 3'd0; mo = 1'b0; to = 1'b0;
      check("done_no_start", start_count, sc);
      check("done_clear", {24'd0, uo_out}, {24'd0, exp_uo()});
      tick(2);
    end
  endtask

  // Acting as the game core: present a result d+1 cycles after the start cycle.
  task automatic respond(logic [1:0] code, int d);
    tick(d + 1);
    uio_in = {5'd0, 1'b1, code};
    tick(1);
    uio_in = 8'h00;
    if (code == 2'b01) s1 = s1 + 3'd1;
    else if (code == 2'b10) s2 = s2 + 3'd1;
    if (s1 == 3'(W) || s2 == 3'(W)) mo = 1'b1;
    #1;
    check("score", {24'd0, uo_out}, {24'd0, exp_uo()});
    tick(1);
  endtask

  initial begin
    int sc;
    do_reset();

    // Tie then invalid move with the game's invalid code
    commit(2'd0, 1'b1); respond(2'b11, 1);
    commit(2'd3, 1'b1); respond(2'b00, 1);
    // Single winning round for P1
    commit(2'd0, 1'b1); respond(2'b01, 1);
    check("single_round_uo", {24'd0, uo_out}, 32'h01);

    // Timeout and its clearing by the next commit
    do_reset();
    commit(2'd1, 1'b1);
    tick(4); #1;
    check("timeout_early", {31'd0, uo_out[7]}, 32'd0);
    tick(1); #1;
    to = 1'b1;
    check("timeout_set", {24'd0, uo_out}, {24'd0, exp_uo()});
    tick(2);
    commit(2'd2, 1'b1); respond(2'b10, 0);

    // Commit pressed while waiting must not start a second round
    commit(2'd1, 1'b1);
    sc = start_count;
    tick(1); ui_in[0] = 1'b1;
    tick(2); ui_in[0] = 1'b0;
    tick(2); #1;
    to = 1'b1;
    check("busy_timeout", {24'd0, uo_out}, {24'd0, exp_uo()});
    tick(6);
    check("busy_no_start", start_count, sc);

    // Dropping ena for 10 cycles stretches the timeout by 10 cycles
    commit(2'd0, 1'b1);
    tick(1); ena = 1'b0;
    tick(10); ena = 1'b1;
    tick(3); #1;
    check("ena_timeout_early", {31'd0, uo_out[7]}, 32'd0);
    tick(1); #1;
    check("ena_timeout_set", {31'd0, uo_out[7]}, 32'd1);
    to = 1'b1;
    tick(2);

    // Reset mid-wait, then a late result must be ignored
    commit(2'd2, 1'b1); respond(2'b01, 0);
    commit(2'd1, 1'b1);
    tick(1); rst_n = 1'b0;
    tick(2); rst_n = 1'b1;
    model_reset();
    uio_in = 8'h05;
    tick(1); uio_in = 8'h00;
    tick(1); #1;
    check("late_result_uo", {24'd0, uo_out}, 32'h00);
    check("late_result_uio", {24'd0, uio_out}, 32'h00);
    tick(1);

    // Match end at three P2 wins, clear, then a fresh round
    do_reset();
    for (int r = 0; r < 3; r++) begin
      commit(2'(r), 1'b1); respond(2'b10, 1);
    end
    check("match_end_uo", {24'd0, uo_out}, 32'h58);
    commit(2'd0, 1'b0);
    commit(2'd1, 1'b1); respond(2'b01, 0);

    // Randomised rounds, including results on the final counted cycle
    for (int r = 0; r < 24; r++) begin
      if (mo) commit(2'($urandom_range(3)), 1'b0);
      commit(2'($urandom_range(3)), 1'b1);
      respond(2'($urandom_range(3)), int'($urandom_range(3)));
    end

    tick(2);
    check("scoreboard_drained", move_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tt_um_sps_match_driver.md
# tt_um_sps_match_driver

Match controller for the stone-paper-scissors game: it is the initiator side of the game's move/start protocol. It takes the human player's move and commit button, generates the opponent's move from an LFSR, and drives moves plus a one-cycle start strobe to the game core. It then waits for the game's result, keeps a first-to-N score and flags timeouts. It is packaged as a TinyTapeout top so it can be tiled next to the game core, or driven stand-alone from a bench.

## Interface

**Parameters**
- `WINS_TO_MATCH`, default 3: wins needed to end a match; legal range 1..7.
- `TIMEOUT`, default 255: cycles to wait for a result after start; legal range 1..255.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

**Ports**
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: when low, every register holds, including the LFSR and synchronisers.
- `ui_in` in 8:
  - [0] commit button (asynchronous).
  - [2:1] player move: 0 stone, 1 paper, 2 scissors, 3 invalid.
  - [7:3] unused.
- `uio_in` in 8: result from the game core.
  - [1:0] result code: 00 invalid, 01 P1 win, 10 P2 win, 11 tie.
  - [2] result_valid.
  - [7:3] unused.
- `uio_out` out 8:
  - [0] start.
  - [2:1] P1 move.
  - [4:3] P2 move.
  - [7:5] constant 0.
- `uio_oe` out 8: constant 8'b0001_1111.
- `uo_out` out 8:
  - [2:0] P1 score.
  - [5:3] P2 score.
  - [6] match_over.
  - [7] timeout_err.

## Operation

**Input conditioning**
- `ui_in[0]` passes through a 2-flop synchroniser, then a registered rising-edge detector, producing `commit_pulse`.
- `ui_in[2:1]` is sampled directly when `commit_pulse` is seen.

**LFSR**
- 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every `ena` cycle.
- Opponent move is `lfsr[1:0]` if that value is not 3; otherwise it is `{1'b0, lfsr[2]}`.
- The opponent move is therefore never 3.

**FSM states:** IDLE, SEND, WAIT, DONE.
- **IDLE**
  - On `commit_pulse`: latch P1 = `ui_in[2:1]` and P2 = the LFSR move, clear timeout_err, go to SEND.
  - `result_valid` is ignored.
- **SEND**
  - start = 1 for exactly this one cycle.
  - Load the timeout counter with `TIMEOUT`, go to WAIT.
- **WAIT**
  - If `result_valid` is high, apply the code:
    - 01: P1 score +1.
    - 10: P2 score +1.
    - 11 or 00: no change.
  - After applying the code: if either score now equals `WINS_TO_MATCH`, go to DONE and set match_over; otherwise go to IDLE.
  - If `result_valid` is low: decrement the counter. If it reaches 0, set timeout_err and go to IDLE with scores unchanged.
  - `commit_pulse` is ignored.
- **DONE**
  - Scores and match_over hold.
  - `commit_pulse` clears both scores and match_over, clears timeout_err, and goes to IDLE without starting a round.

**Output rules**
- The latched moves on `uio_out[4:1]` hold from SEND until the next latch; they are not cleared on round end.
- Scores never exceed `WINS_TO_MATCH`, so 3 bits never wrap.
- timeout_err is sticky until the next accepted commit or reset.
- A commit while `ui_in[2:1]` = 3 is legal: the invalid move is sent and the game's 00 code scores nothing.

## Timing

**Reset**
- While `rst_n` = 0 at a rising edge:
  - FSM goes to IDLE.
  - LFSR loads `LFSR_SEED`.
  - Synchronisers, edge detector, moves, scores, match_over, timeout_err and counter are all cleared.
- Resulting outputs:
  - `uo_out` = 0.
  - `uio_out` = 0.
  - `uio_oe` = 8'h1F.
- Reset in any state, including mid-WAIT, aborts the round; a late `result_valid` arriving afterwards is ignored.

**Latencies**
- Commit: `ui_in[0]` rising before edge 0 gives `commit_pulse` high after edge 2; the FSM enters SEND after edge 3, so start is visible in the cycle after edge 3, for one cycle.
- Result: `result_valid` sampled high at edge k gives the updated score and match_over visible after edge k.
- The earliest accepted result is one cycle after start, i.e. in the first WAIT cycle.
- Timeout: with no valid result, timeout_err rises `TIMEOUT` cycles after WAIT entry.

**Simultaneous events**
- `result_valid` in the same cycle the counter reaches 0: the result wins and timeout_err stays 0.
- `ena` low freezes the FSM mid-round; the timeout counter does not advance.

## Test plan

- **Reset:** hold `rst_n`=0 for 2 cycles with random inputs -> `uo_out`=0, `uio_out`=0, `uio_oe`=8'h1F.
- **Single round:** set `ui_in[2:1]`=0 and pulse `ui_in[0]`; the bench acts as game and returns code 01 with valid two cycles after start -> start is high for exactly 1 cycle, `uio_out[2:1]`=0, `uio_out[4:3]`≠3, `uo_out`=8'h01.
- **Tie and invalid:** return code 11, then code 00 in a second round -> scores unchanged at 0/0; timeout_err=0.
- **Timeout:** with `TIMEOUT`=4, commit and never assert valid -> `uo_out[7]`=1 exactly 4 cycles after WAIT entry, FSM back in IDLE; the next commit clears it.
- **Match end:** play 3 rounds all returning 10 -> `uo_out`=8'h58 (P2=3, match_over=1). A further commit gives `uo_out`=0 and no start pulse; the following commit starts a new round.
- **Busy and hold:** commit pulses during WAIT produce no extra start. Dropping `ena` mid-WAIT for 10 cycles extends the timeout by 10 cycles. Reset during WAIT followed by a valid result leaves scores at 0.
